lpif_tx_flit_buffer: RTL and testbench

Parametrised LPIF transmit-side flit buffer between the link-layer packer and the PHY/MAC LPIF TX port. It generalises the fixed 64-byte LPIF TX bundle to BYTES lanes. It adds a DEPTH-entry FIFO, lp_irdy/pl_trdy flow control, transmit gating on link state, link-down flush, and sticky overflow/framing error flags.

---
 rtl/lpif_tx_flit_buffer_if.sv | 46 ++++
 rtl/lpif_tx_flit_buffer.sv | 96 +++++++++
 tb/tb_lpif_tx_flit_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lpif_tx_flit_buffer_if.sv
// LPIF TX flit buffer bus: link-layer write side, PHY handshake/status, and
// buffered LPIF TX outputs with occupancy and sticky error flags.
interface lpif_tx_flit_buffer_if #(
  parameter int BYTES = 64,
  parameter int DEPTH = 8
);
  localparam int OW = $clog2(DEPTH + 1);

  logic                 ll_wr_en;
  logic [8*BYTES-1:0]   ll_data;
  logic [BYTES-1:0]     ll_valid;
  logic [BYTES-1:0]     ll_tlpstart;
  logic [BYTES-1:0]     ll_tlpend;
  logic [BYTES-1:0]     ll_dlpstart;
  logic [BYTES-1:0]     ll_dlpend;
  logic                 ll_full;

  logic                 pl_trdy;
  logic [3:0]           pl_state_sts;
  logic                 pl_linkUp;

  logic                 lp_irdy;
  logic [8*BYTES-1:0]   lp_data;
  logic [BYTES-1:0]     lp_valid;
  logic [BYTES-1:0]     lp_tlpstart;
  logic [BYTES-1:0]     lp_tlpend;
  logic [BYTES-1:0]     lp_dlpstart;
  logic [BYTES-1:0]     lp_dlpend;
  logic [OW-1:0]        occupancy;
  logic                 overflow_err;
  logic                 framing_err;

  modport slave (
    input  ll_wr_en, ll_data, ll_valid, ll_tlpstart, ll_tlpend, ll_dlpstart, ll_dlpend,
    input  pl_trdy, pl_state_sts, pl_linkUp,
    output ll_full, lp_irdy, lp_data, lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend,
    output occupancy, overflow_err, framing_err
  );

  modport master (
    output ll_wr_en, ll_data, ll_valid, ll_tlpstart, ll_tlpend, ll_dlpstart, ll_dlpend,
    output pl_trdy, pl_state_sts, pl_linkUp,
    input  ll_full, lp_irdy, lp_data, lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend,
    input  occupancy, overflow_err, framing_err
  );
endinterface

// File: rtl/lpif_tx_flit_buffer.sv
// LPIF TX flit FIFO: DEPTH entries, irdy/trdy pop, link-state gated output,
// flush while link is down, sticky overflow/framing flags.
module lpif_tx_flit_buffer #(
  parameter int         BYTES      = 64,
  parameter int         DEPTH      = 8,
  parameter logic [3:0] ACTIVE_STS = 4'h1
) (
  input  logic                lclk,
  input  logic                lpreset,
  lpif_tx_flit_buffer_if.slave bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam int            OW       = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

  typedef struct packed {
    logic [8*BYTES-1:0] data;
    logic [BYTES-1:0]   valid;
    logic [BYTES-1:0]   tlps;
    logic [BYTES-1:0]   tlpe;
    logic [BYTES-1:0]   dlps;
    logic [BYTES-1:0]   dlpe;
  } flit_t;

  flit_t          r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]  r_occ;
  logic           r_ovf, r_frm;

  logic           w_tx_en, w_full, w_wr, w_irdy, w_pop, w_bad;
  flit_t          w_in, w_head;

  assign w_tx_en = bus.pl_linkUp && (bus.pl_state_sts == ACTIVE_STS);
  assign w_full  = (r_occ == FULL_CNT);
  assign w_wr    = bus.ll_wr_en && !w_full && bus.pl_linkUp;
  assign w_irdy  = w_tx_en && (r_occ != '0);
  assign w_pop   = w_irdy && bus.pl_trdy;

  // Markers on invalid bytes are stripped before storage but still flagged.
  assign w_in.data  = bus.ll_data;
  assign w_in.valid = bus.ll_valid;
  assign w_in.tlps  = bus.ll_tlpstart & bus.ll_valid;
  assign w_in.tlpe  = bus.ll_tlpend   & bus.ll_valid;
  assign w_in.dlps  = bus.ll_dlpstart & bus.ll_valid;
  assign w_in.dlpe  = bus.ll_dlpend   & bus.ll_valid;
  assign w_bad = |((bus.ll_tlpstart | bus.ll_tlpend | bus.ll_dlpstart | bus.ll_dlpend)
                   & ~bus.ll_valid);

  always_ff @(posedge lclk)
    if (w_wr) r_mem[r_wr_ptr] <= w_in;

  always_ff @(posedge lclk or posedge lpreset) begin
    if (lpreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (!bus.pl_linkUp) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Error flags survive link-down flush; only lpreset clears them.
  always_ff @(posedge lclk or posedge lpreset) begin
    if (lpreset) begin
      r_ovf <= 1'b0;
      r_frm <= 1'b0;
    end else begin
      if (bus.ll_wr_en && w_full && bus.pl_linkUp) r_ovf <= 1'b1;
      if (w_wr && w_bad)                           r_frm <= 1'b1;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.ll_full      = w_full;
  assign bus.lp_irdy      = w_irdy;
  assign bus.lp_data      = w_irdy ? w_head.data  : '0;
  assign bus.lp_valid     = w_irdy ? w_head.valid : '0;
  assign bus.lp_tlpstart  = w_irdy ? w_head.tlps  : '0;
  assign bus.lp_tlpend    = w_irdy ? w_head.tlpe  : '0;
  assign bus.lp_dlpstart  = w_irdy ? w_head.dlps  : '0;
  assign bus.lp_dlpend    = w_irdy ? w_head.dlpe  : '0;
  assign bus.occupancy    = r_occ;
  assign bus.overflow_err = r_ovf;
  assign bus.framing_err  = r_frm;
endmodule

// File: tb/tb_lpif_tx_flit_buffer.sv
// Directed bench for lpif_tx_flit_buffer: pass-through, full/overflow, wrap,
// framing, state gating, flush and mid-stream reset.
module tb_lpif_tx_flit_buffer;
  localparam int BYTES = 64;
  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH + 1);

  logic lclk = 1'b0;
  logic lpreset;
  int   errs = 0;
  int   checks = 0;

  lpif_tx_flit_buffer_if #(.BYTES(BYTES), .DEPTH(DEPTH)) bus();

  lpif_tx_flit_buffer #(.BYTES(BYTES), .DEPTH(DEPTH), .ACTIVE_STS(4'h1)) dut (
    .lclk(lclk), .lpreset(lpreset), .bus(bus)
  );

  always #5 lclk = ~lclk;

  function automatic logic [8*BYTES-1:0] mk(input logic [7:0] b);
    return {{(BYTES-1){~b}}, b};
  endfunction

  task automatic cyc();
    @(posedge lclk); #1;
  endtask

  task automatic idle();
    bus.ll_wr_en = 1'b0; bus.ll_data = '0; bus.ll_valid = '0;
    bus.ll_tlpstart = '0; bus.ll_tlpend = '0; bus.ll_dlpstart = '0; bus.ll_dlpend = '0;
  endtask

  task automatic put(input logic [7:0] b);
    bus.ll_wr_en = 1'b1; bus.ll_data = mk(b); bus.ll_valid = '1;
    bus.ll_tlpstart = '0; bus.ll_tlpend = '0; bus.ll_dlpstart = '0; bus.ll_dlpend = '0;
  endtask

  task automatic test_reset();
    lpreset = 1'b1; idle();
    bus.pl_trdy = 1'b0; bus.pl_state_sts = 4'h1; bus.pl_linkUp = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.lp_irdy !== 1'b0) begin errs++; $display("FAIL rst_irdy: got %0h exp 0", bus.lp_irdy); end
    checks++; if (bus.occupancy !== '0) begin errs++; $display("FAIL rst_occ: got %0d exp 0", bus.occupancy); end
    checks++; if (bus.ll_full !== 1'b0) begin errs++; $display("FAIL rst_full: got %0h exp 0", bus.ll_full); end
    checks++; if ({bus.overflow_err, bus.framing_err} !== 2'b00) begin errs++; $display("FAIL rst_errs: got %0h exp 0", {bus.overflow_err, bus.framing_err}); end
    lpreset = 1'b0;
    cyc();
    checks++; if (bus.lp_data !== '0 || bus.lp_irdy !== 1'b0) begin errs++; $display("FAIL rst_post: got irdy %0h exp 0", bus.lp_irdy); end
  endtask

  task automatic test_basic();
    logic [BYTES-1:0] ts, te;
    bus.pl_trdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(8'(8'hA0 + i));
      ts = (i == 0) ? BYTES'(1) : '0;
      te = (i == 3) ? {1'b1, {(BYTES-1){1'b0}}} : '0;
      bus.ll_tlpstart = ts; bus.ll_tlpend = te;
      cyc();
      checks++; if (bus.lp_irdy !== 1'b1 || bus.lp_data !== mk(8'(8'hA0 + i))) begin
        errs++; $display("FAIL basic_data[%0d]: got irdy %0h byte0 %0h exp irdy 1 byte0 %0h", i, bus.lp_irdy, bus.lp_data[7:0], 8'(8'hA0 + i)); end
      checks++; if (bus.lp_tlpstart !== ts || bus.lp_tlpend !== te || bus.lp_valid !== '1) begin
        errs++; $display("FAIL basic_mark[%0d]: got ts %0h te %0h exp ts %0h te %0h", i, bus.lp_tlpstart, bus.lp_tlpend, ts, te); end
    end
    idle();
    cyc();
    checks++; if (bus.occupancy !== '0 || bus.lp_irdy !== 1'b0) begin
      errs++; $display("FAIL basic_drain: got occ %0d irdy %0h exp 0 0", bus.occupancy, bus.lp_irdy); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int sent = 0, got = 0, n = 0;
    logic wr;
    while ((sent < 20 || q.size() != 0) && n < 200) begin
      bus.pl_trdy = (n % 2 == 0);
      wr = (sent < 20) && (q.size() < DEPTH);
      if (wr) put(8'(8'h40 + sent)); else idle();
      #1;
      checks++; if (bus.occupancy !== OW'(q.size()) || bus.ll_full !== (q.size() == DEPTH)) begin
        errs++; $display("FAIL wrap_occ: got occ %0d full %0h exp %0d", bus.occupancy, bus.ll_full, q.size()); end
      checks++; if (bus.lp_irdy !== (q.size() != 0)) begin
        errs++; $display("FAIL wrap_irdy: got %0h exp %0h", bus.lp_irdy, q.size() != 0); end
      if (q.size() != 0 && bus.pl_trdy) begin
        checks++; if (bus.lp_data !== mk(q[0])) begin
          errs++; $display("FAIL wrap_data: got %0h exp %0h", bus.lp_data[7:0], q[0]); end
        void'(q.pop_front()); got++;
      end
      if (wr) begin q.push_back(8'(8'h40 + sent)); sent++; end
      n++;
      cyc();
    end
    idle();
    checks++; if (got != 20 || n >= 200) begin errs++; $display("FAIL wrap_count: got %0d exp 20 (cycles %0d)", got, n); end
    checks++; if (bus.overflow_err !== 1'b0) begin errs++; $display("FAIL wrap_ovf: got %0h exp 0", bus.overflow_err); end
  endtask

  task automatic test_full();
    bus.pl_trdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(8'(8'h10 + i));
      cyc();
      checks++; if (bus.occupancy !== OW'((i < 8) ? i + 1 : 8) || bus.lp_data !== mk(8'h10)) begin
        errs++; $display("FAIL full_fill[%0d]: got occ %0d byte0 %0h exp %0d 10", i, bus.occupancy, bus.lp_data[7:0], (i < 8) ? i + 1 : 8); end
      if (i >= 6) begin
        checks++; if (bus.ll_full !== (i >= 7)) begin errs++; $display("FAIL full_flag[%0d]: got %0h exp %0h", i, bus.ll_full, i >= 7); end
      end
    end
    checks++; if (bus.overflow_err !== 1'b1) begin errs++; $display("FAIL full_ovf: got %0h exp 1", bus.overflow_err); end
    idle(); bus.pl_trdy = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.lp_irdy !== 1'b1 || bus.lp_data !== mk(8'(8'h10 + k))) begin
        errs++; $display("FAIL full_drain[%0d]: got irdy %0h byte0 %0h exp 1 %0h", k, bus.lp_irdy, bus.lp_data[7:0], 8'(8'h10 + k)); end
      cyc();
    end
    checks++; if (bus.lp_irdy !== 1'b0 || bus.occupancy !== '0) begin
      errs++; $display("FAIL full_empty: got irdy %0h occ %0d exp 0 0", bus.lp_irdy, bus.occupancy); end
  endtask

  task automatic test_framing();
    bus.pl_trdy = 1'b0;
    checks++; if (bus.framing_err !== 1'b0) begin errs++; $display("FAIL frm_pre: got %0h exp 0", bus.framing_err); end
    put(8'h55);
    bus.ll_valid = ~(BYTES'(1) << 5); bus.ll_tlpstart = BYTES'(1) << 5;
    cyc();
    idle();
    checks++; if (bus.framing_err !== 1'b1) begin errs++; $display("FAIL frm_flag: got %0h exp 1", bus.framing_err); end
    checks++; if (bus.lp_irdy !== 1'b1 || bus.lp_tlpstart !== '0 || bus.lp_valid !== ~(BYTES'(1) << 5)) begin
      errs++; $display("FAIL frm_mask: got irdy %0h ts %0h exp 1 0", bus.lp_irdy, bus.lp_tlpstart); end
    bus.pl_trdy = 1'b1;
    cyc();
    checks++; if (bus.occupancy !== '0) begin errs++; $display("FAIL frm_drain: got %0d exp 0", bus.occupancy); end
  endtask

  task automatic test_gating_flush();
    bus.pl_trdy = 1'b0;
    for (int i = 0; i < 3; i++) begin put(8'(8'h60 + i)); cyc(); end
    idle(); bus.pl_state_sts = 4'h3; bus.pl_trdy = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.lp_irdy !== 1'b0 || bus.lp_data !== '0 || bus.occupancy !== OW'(3)) begin
      errs++; $display("FAIL gate_hold: got irdy %0h occ %0d exp 0 3", bus.lp_irdy, bus.occupancy); end
    bus.pl_state_sts = 4'h1; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.lp_irdy !== 1'b1 || bus.lp_data !== mk(8'(8'h60 + k))) begin
        errs++; $display("FAIL gate_emit[%0d]: got irdy %0h byte0 %0h exp 1 %0h", k, bus.lp_irdy, bus.lp_data[7:0], 8'(8'h60 + k)); end
      cyc();
    end
    checks++; if (bus.lp_irdy !== 1'b0) begin errs++; $display("FAIL gate_done: got %0h exp 0", bus.lp_irdy); end
    bus.pl_trdy = 1'b0;
    for (int i = 0; i < 3; i++) begin put(8'(8'h70 + i)); cyc(); end
    idle(); bus.pl_linkUp = 1'b0;
    cyc();
    checks++; if (bus.occupancy !== '0 || bus.lp_irdy !== 1'b0) begin
      errs++; $display("FAIL flush_occ: got occ %0d irdy %0h exp 0 0", bus.occupancy, bus.lp_irdy); end
    bus.pl_linkUp = 1'b1; bus.pl_trdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (bus.lp_irdy !== 1'b0) begin errs++; $display("FAIL flush_noemit[%0d]: got %0h exp 0", k, bus.lp_irdy); end
    end
    checks++; if (bus.framing_err !== 1'b1 || bus.overflow_err !== 1'b1) begin
      errs++; $display("FAIL flush_errs: got ovf %0h frm %0h exp 1 1", bus.overflow_err, bus.framing_err); end
  endtask

  task automatic test_reset_midstream();
    bus.pl_trdy = 1'b0;
    put(8'h80); cyc(); put(8'h81); cyc();
    checks++; if (bus.occupancy !== OW'(2)) begin errs++; $display("FAIL mrst_pre: got %0d exp 2", bus.occupancy); end
    put(8'h82); lpreset = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.lp_irdy !== 1'b0 || bus.lp_data !== '0 || bus.occupancy !== '0 || bus.ll_full !== 1'b0
                    || bus.overflow_err !== 1'b0 || bus.framing_err !== 1'b0) begin
        errs++; $display("FAIL mrst_during[%0d]: got irdy %0h occ %0d ovf %0h frm %0h exp all 0", k, bus.lp_irdy, bus.occupancy, bus.overflow_err, bus.framing_err); end
      cyc();
    end
    idle(); lpreset = 1'b0; bus.pl_trdy = 1'b1;
    cyc();
    checks++; if (bus.lp_irdy !== 1'b0 || bus.occupancy !== '0 || bus.overflow_err !== 1'b0 || bus.framing_err !== 1'b0) begin
      errs++; $display("FAIL mrst_after: got irdy %0h occ %0d exp 0 0", bus.lp_irdy, bus.occupancy); end
    put(8'h90); cyc(); idle();
    checks++; if (bus.lp_irdy !== 1'b1 || bus.lp_data !== mk(8'h90)) begin
      errs++; $display("FAIL mrst_fresh: got irdy %0h byte0 %0h exp 1 90", bus.lp_irdy, bus.lp_data[7:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_framing();
    test_gating_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
